pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised successor to the 16-bit load-enabled PC register.
- Holds the program counter and selects the next PC internally from four sources: increment, bus, address adder, return-stack pop.
- Contains a small circular return-address stack for JSR/RET.
- Sits in the datapath, feeding MAR/PCMUX consumers, and is controlled by the FSM control unit.

Parameters:
- WIDTH, 16: PC and address width in bits.
- RESET_VECTOR, 16'h3000: PC value after reset; truncated/zero-extended to WIDTH.
- RS_DEPTH, 4: return-stack entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on falling edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ld_pc  in  1  load enable; no state changes when 0.
- pc_sel  in  2  next-PC source: 00 PC+1, 01 bus_in, 10 addr_in, 11 return-stack pop.
- push  in  1  with ld_pc=1, save PC+1 onto the return stack (JSR).
- bus_in  in  WIDTH  value from the system bus.
- addr_in  in  WIDTH  value from the address adder.
- clear_err  in  1  clears the sticky error flags.
- pc_out  out  WIDTH  current PC.
- pc_plus1  out  WIDTH  combinational PC+1, modulo 2^WIDTH.
- rs_empty  out  1  stack holds 0 entries.
- rs_full  out  1  stack holds RS_DEPTH entries.
- rs_overflow  out  1  sticky: a push was made while full.
- rs_underflow  out  1  sticky: a pop was made while empty.

Behaviour:
- Reset (async, any time, including mid-load): pc_out=RESET_VECTOR, stack count=0, top pointer=0, rs_empty=1, rs_full=0, rs_overflow=0, rs_underflow=0.
- All state changes on the negedge of clk only when reset=0.
- ld_pc=0: PC, stack and flags hold; push and pop are ignored.
- ld_pc=1, pc_sel=00/01/10: PC <= pc_plus1 / bus_in / addr_in respectively. One-edge latency, visible on pc_out after the edge.
- ld_pc=1, pc_sel=11, stack non-empty: PC <= top entry; count decrements; top pointer moves back by one (mod RS_DEPTH).
- ld_pc=1, pc_sel=11, stack empty: PC holds; count stays 0; rs_underflow <= 1.
- push with ld_pc=1, not popping: entry <= PC+1 (pre-load value); count increments.
- Push when full: the oldest entry is overwritten (circular); count stays RS_DEPTH; rs_overflow <= 1.
- Simultaneous push and pop, stack non-empty: PC <= old top; the top slot is overwritten with old PC+1; count unchanged; no flags set.
- Simultaneous push and pop, stack empty: PC holds; PC+1 is pushed (count=1); rs_underflow <= 1.
- clear_err on an edge clears both sticky flags. If an error occurs on the same edge, setting wins.
- Arithmetic: PC+1 wraps from all-ones to 0. There is no carry output.
- rs_empty and rs_full are decoded combinationally from count.

Optional Feature:
- Macro PC_UNIT_TRACE_EN.
- Defined: adds output prev_pc (WIDTH), which captures the pre-load pc_out on every edge with ld_pc=1. Reset value is RESET_VECTOR. Used for trap/interrupt return debug.
- Undefined: prev_pc port and register absent; all other behaviour identical.

Decomposition:
- Package pc_pkg: pc_sel encodings as localparam constants PC_SEL_INC=2'b00, PC_SEL_BUS=2'b01, PC_SEL_ADDR=2'b10, PC_SEL_POP=2'b11; the default RESET_VECTOR constant.
- Sub-module pc_return_stack: parametrised by WIDTH and RS_DEPTH. Holds the storage array, pointer, count, and full/empty/overflow/underflow logic. Interface: push, pop, push_data, top_data, flags.
- pc_unit instantiates the PC register, source mux, incrementer and pc_return_stack.

Test Plan:
- Reset then 3 edges with ld_pc=1, pc_sel=00 -> pc_out 3000, 3001, 3002, 3003; assert reset mid-cycle -> pc_out=3000 immediately, before the next edge.
- PC=3005; push=1, pc_sel=10, addr_in=4000 -> pc_out=4000, rs_empty=0; next edge pc_sel=11 -> pc_out=3006, rs_empty=1.
- RS_DEPTH=4: 5 pushes from PCs 10,20,30,40,50 -> rs_full=1, rs_overflow=1; then 4 pops -> 51, 41, 31, 21; 5th pop -> PC holds, rs_underflow=1.
- Stack top=1234, PC=0200: push and pop together -> pc_out=1234, top becomes 0201, count unchanged, no flags set.
- pc_sel=01, bus_in=FFFF, then pc_sel=00 -> pc_out=0000 (wrap); ld_pc=0 with push=1 -> no change anywhere.
- With PC_UNIT_TRACE_EN defined: loads 3000 -> 4000 -> 5000 give prev_pc 3000 then 4000; clear_err clears the sticky flags.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: next-PC source encodings and the default reset vector
package pc_pkg;
    localparam logic [1:0] PC_SEL_INC  = 2'b00;
    localparam logic [1:0] PC_SEL_BUS  = 2'b01;
    localparam logic [1:0] PC_SEL_ADDR = 2'b10;
    localparam logic [1:0] PC_SEL_POP  = 2'b11;
    localparam logic [15:0] PC_RESET_VECTOR = 16'h3000;
endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: circular return-address stack; a push when full overwrites the oldest entry
module pc_return_stack #(
    parameter int WIDTH = 16,
    parameter int RS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear_err,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);
    localparam int PW = $clog2(RS_DEPTH);
    localparam int CW = $clog2(RS_DEPTH + 1);
    logic [WIDTH-1:0] mem [RS_DEPTH];
    logic [PW-1:0] top, top_nxt, wr_idx;
    logic [CW-1:0] count, count_nxt;
    logic replace, grow, shrink, ovf_set, unf_set;
    assign empty = count == '0;
    assign full = count == CW'(RS_DEPTH);
    assign top_data = mem[top];
    // classify the operation: replace the top on push+pop, otherwise grow or shrink
    always_comb begin
        replace = push && pop && !empty;
        grow = push && !replace;
        shrink = pop && !push && !empty;
        ovf_set = grow && full;
        unf_set = pop && empty;
        wr_idx = replace ? top : top + PW'(1);
        top_nxt = grow ? top + PW'(1) : shrink ? top - PW'(1) : top;
        count_nxt = (grow && !full) ? count + CW'(1) : shrink ? count - CW'(1) : count;
    end
    // storage, pointer, count and sticky flags; an error on the same edge beats clear_err
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RS_DEPTH; i++) mem[i] <= '0;
            top <= '0;
            count <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (grow || replace) mem[wr_idx] <= push_data;
            top <= top_nxt;
            count <= count_nxt;
            overflow <= ovf_set || (overflow && !clear_err);
            underflow <= unf_set || (underflow && !clear_err);
        end
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with internal next-PC mux and return stack; PC_UNIT_TRACE_EN adds prev_pc
module pc_unit
    import pc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter logic [15:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter int RS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_pc,
    input  logic [1:0]       pc_sel,
    input  logic             push,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [WIDTH-1:0] addr_in,
    input  logic             clear_err,
`ifdef PC_UNIT_TRACE_EN
    output logic [WIDTH-1:0] prev_pc,
`endif
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus1,
    output logic             rs_empty,
    output logic             rs_full,
    output logic             rs_overflow,
    output logic             rs_underflow
);
    localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VECTOR);
    logic [WIDTH-1:0] pc_nxt, top_data;
    logic pop_en, push_en;
    assign pc_plus1 = pc_out + WIDTH'(1);
    assign pop_en = ld_pc && pc_sel == PC_SEL_POP;
    assign push_en = ld_pc && push;
    // next-PC source select; a pop from an empty stack holds the PC
    always_comb begin
        pc_nxt = !ld_pc ? pc_out :
                 pc_sel == PC_SEL_INC  ? pc_plus1 :
                 pc_sel == PC_SEL_BUS  ? bus_in :
                 pc_sel == PC_SEL_ADDR ? addr_in :
                 rs_empty ? pc_out : top_data;
    end
    // PC register
    always_ff @(negedge clk or posedge reset) begin
        if (reset) pc_out <= RV;
        else pc_out <= pc_nxt;
    end
`ifdef PC_UNIT_TRACE_EN
    // remember the PC that was current before each load
    always_ff @(negedge clk or posedge reset) begin
        if (reset) prev_pc <= RV;
        else if (ld_pc) prev_pc <= pc_out;
    end
`endif
    pc_return_stack #(.WIDTH(WIDTH), .RS_DEPTH(RS_DEPTH)) u_rs (
        .clk(clk),
        .reset(reset),
        .push(push_en),
        .pop(pop_en),
        .clear_err(clear_err),
        .push_data(pc_plus1),
        .top_data(top_data),
        .empty(rs_empty),
        .full(rs_full),
        .overflow(rs_overflow),
        .underflow(rs_underflow)
    );
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table vectors plus random stimulus against a queue-based return-stack model
module tb_pc_unit;
    localparam int DEPTH = 4;
    logic clk = 1'b0, reset = 1'b1, ld_pc = 1'b0, push = 1'b0, clear_err = 1'b0;
    logic [1:0] pc_sel = 2'b00;
    logic [15:0] bus_in = '0, addr_in = '0;
    logic [15:0] pc_out, pc_plus1;
    logic rs_empty, rs_full, rs_overflow, rs_underflow;
`ifdef PC_UNIT_TRACE_EN
    logic [15:0] prev_pc;
`endif
    int vectors = 0, miscompares = 0;

    pc_unit dut (
        .clk(clk), .reset(reset), .ld_pc(ld_pc), .pc_sel(pc_sel), .push(push),
        .bus_in(bus_in), .addr_in(addr_in), .clear_err(clear_err),
`ifdef PC_UNIT_TRACE_EN
        .prev_pc(prev_pc),
`endif
        .pc_out(pc_out), .pc_plus1(pc_plus1), .rs_empty(rs_empty), .rs_full(rs_full),
        .rs_overflow(rs_overflow), .rs_underflow(rs_underflow)
    );

    always #5 clk = ~clk;

    logic [15:0] m_pc, m_prev;
    logic [15:0] m_q[$];
    logic m_ovf, m_und;

    typedef struct {
        logic ld; logic [1:0] sel; logic psh; logic [15:0] bus; logic [15:0] addr; logic clr;
        logic [15:0] pc; logic emp; logic ful; logic ovf; logic und;
    } vec_t;
    vec_t tbl[$];

    task automatic model_reset();
        m_pc = 16'h3000; m_prev = 16'h3000; m_q.delete(); m_ovf = 0; m_und = 0;
    endtask

    task automatic model_step(input logic ld, input logic [1:0] sel, input logic psh,
                              input logic [15:0] bus, input logic [15:0] addr, input logic clr);
        logic o, u;
        logic [15:0] t, inc;
        o = 0; u = 0; inc = m_pc + 16'd1;
        if (ld) begin
            m_prev = m_pc;
            if (sel == 2'b11) begin
                if (m_q.size() == 0) begin
                    u = 1;
                    if (psh) m_q.push_back(inc);
                end else begin
                    t = m_q.pop_back();
                    if (psh) m_q.push_back(inc);
                    m_pc = t;
                end
            end else begin
                if (psh) begin
                    if (m_q.size() == DEPTH) begin o = 1; void'(m_q.pop_front()); end
                    m_q.push_back(inc);
                end
                m_pc = sel == 2'b00 ? inc : sel == 2'b01 ? bus : addr;
            end
        end
        m_ovf = o | (m_ovf & ~clr);
        m_und = u | (m_und & ~clr);
    endtask

    task automatic check(input string name, input logic [15:0] epc, input logic ee,
                         input logic ef, input logic eo, input logic eu);
        logic [15:0] ep1;
        logic [35:0] got, exp;
        ep1 = epc + 16'd1;
        got = {pc_out, pc_plus1, rs_empty, rs_full, rs_overflow, rs_underflow};
        exp = {epc, ep1, ee, ef, eo, eu};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got pc=%h p1=%h e=%b f=%b o=%b u=%b, want pc=%h p1=%h e=%b f=%b o=%b u=%b",
                     name, pc_out, pc_plus1, rs_empty, rs_full, rs_overflow, rs_underflow,
                     epc, ep1, ee, ef, eo, eu);
        end
`ifdef PC_UNIT_TRACE_EN
        vectors++;
        if (prev_pc !== m_prev) begin
            miscompares++;
            $display("FAIL %s prev_pc: got %h want %h", name, prev_pc, m_prev);
        end
`endif
    endtask

    task automatic apply(input logic ld, input logic [1:0] sel, input logic psh,
                         input logic [15:0] bus, input logic [15:0] addr, input logic clr);
        ld_pc = ld; pc_sel = sel; push = psh; bus_in = bus; addr_in = addr; clear_err = clr;
        model_step(ld, sel, psh, bus, addr, clr);
        @(negedge clk);
        #1;
    endtask

    task automatic add(input logic ld, input logic [1:0] sel, input logic psh, input logic [15:0] bus,
                       input logic [15:0] addr, input logic clr, input logic [15:0] pc,
                       input logic emp, input logic ful, input logic ovf, input logic und);
        vec_t v;
        v.ld = ld; v.sel = sel; v.psh = psh; v.bus = bus; v.addr = addr; v.clr = clr;
        v.pc = pc; v.emp = emp; v.ful = ful; v.ovf = ovf; v.und = und;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #3;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        // increment run, then mid-cycle reset
        add(1, 2'b00, 0, 16'h0, 16'h0, 0, 16'h3001, 1, 0, 0, 0);
        add(1, 2'b00, 0, 16'h0, 16'h0, 0, 16'h3002, 1, 0, 0, 0);
        add(1, 2'b00, 0, 16'h0, 16'h0, 0, 16'h3003, 1, 0, 0, 0);
        // JSR then RET
        add(1, 2'b01, 0, 16'h3005, 16'h0, 0, 16'h3005, 1, 0, 0, 0);
        add(1, 2'b10, 1, 16'h0, 16'h4000, 0, 16'h4000, 0, 0, 0, 0);
        add(1, 2'b11, 0, 16'h0, 16'h0, 0, 16'h3006, 1, 0, 0, 0);
        // five pushes into a four-deep stack, then five pops
        add(1, 2'b01, 0, 16'h0010, 16'h0, 0, 16'h0010, 1, 0, 0, 0);
        add(1, 2'b01, 1, 16'h0020, 16'h0, 0, 16'h0020, 0, 0, 0, 0);
        add(1, 2'b01, 1, 16'h0030, 16'h0, 0, 16'h0030, 0, 0, 0, 0);
        add(1, 2'b01, 1, 16'h0040, 16'h0, 0, 16'h0040, 0, 0, 0, 0);
        add(1, 2'b01, 1, 16'h0050, 16'h0, 0, 16'h0050, 0, 1, 0, 0);
        add(1, 2'b01, 1, 16'h0060, 16'h0, 0, 16'h0060, 0, 1, 1, 0);
        add(1, 2'b11, 0, 16'h0, 16'h0, 0, 16'h0051, 0, 0, 1, 0);
        add(1, 2'b11, 0, 16'h0, 16'h0, 0, 16'h0041, 0, 0, 1, 0);
        add(1, 2'b11, 0, 16'h0, 16'h0, 0, 16'h0031, 0, 0, 1, 0);
        add(1, 2'b11, 0, 16'h0, 16'h0, 0, 16'h0021, 1, 0, 1, 0);
        add(1, 2'b11, 0, 16'h0, 16'h0, 0, 16'h0021, 1, 0, 1, 1);
        add(1, 2'b00, 0, 16'h0, 16'h0, 1, 16'h0022, 1, 0, 0, 0);
        // simultaneous push and pop on a non-empty stack
        add(1, 2'b01, 0, 16'h1233, 16'h0, 0, 16'h1233, 1, 0, 0, 0);
        add(1, 2'b01, 1, 16'h0200, 16'h0, 0, 16'h0200, 0, 0, 0, 0);
        add(1, 2'b11, 1, 16'h0, 16'h0, 0, 16'h1234, 0, 0, 0, 0);
        add(1, 2'b11, 0, 16'h0, 16'h0, 0, 16'h0201, 1, 0, 0, 0);
        // wrap, then ld_pc=0 ignores everything
        add(1, 2'b01, 0, 16'hFFFF, 16'h0, 0, 16'hFFFF, 1, 0, 0, 0);
        add(1, 2'b00, 0, 16'h0, 16'h0, 0, 16'h0000, 1, 0, 0, 0);
        add(0, 2'b11, 1, 16'h1111, 16'h2222, 0, 16'h0000, 1, 0, 0, 0);
        // push and pop on an empty stack, clear, and set-beats-clear
        add(1, 2'b11, 1, 16'h0, 16'h0, 0, 16'h0000, 0, 0, 0, 1);
        add(1, 2'b00, 0, 16'h0, 16'h0, 1, 16'h0001, 0, 0, 0, 0);
        add(1, 2'b11, 0, 16'h0, 16'h0, 0, 16'h0001, 1, 0, 0, 0);
        add(1, 2'b11, 0, 16'h0, 16'h0, 1, 16'h0001, 1, 0, 0, 1);

        #2;
        @(negedge clk);
        #1;
        check("reset", 16'h3000, 1, 0, 0, 0);
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].ld, tbl[i].sel, tbl[i].psh, tbl[i].bus, tbl[i].addr, tbl[i].clr);
            check($sformatf("vec%0d", i), tbl[i].pc, tbl[i].emp, tbl[i].ful, tbl[i].ovf, tbl[i].und);
            if (i == 2) begin
                ld_pc = 1'b1; pc_sel = 2'b01; bus_in = 16'hBEEF;
                #2;
                reset = 1'b1;
                model_reset();
                #1;
                check("async_reset", 16'h3000, 1, 0, 0, 0);
                @(negedge clk);
                #1;
                check("reset_held", 16'h3000, 1, 0, 0, 0);
                reset = 1'b0;
            end
        end

`ifdef PC_UNIT_TRACE_EN
        do_reset();
        apply(1, 2'b01, 0, 16'h4000, 16'h0, 0);
        vectors++;
        if (prev_pc !== 16'h3000) begin miscompares++; $display("FAIL trace1: got %h want 3000", prev_pc); end
        apply(1, 2'b01, 0, 16'h5000, 16'h0, 0);
        vectors++;
        if (prev_pc !== 16'h4000) begin miscompares++; $display("FAIL trace2: got %h want 4000", prev_pc); end
`endif

        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic ld, psh, clr;
            logic [1:0] sel;
            ld = $urandom_range(0, 9) != 0;
            sel = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            psh = $urandom_range(0, 2) == 0;
            clr = ld && $urandom_range(0, 15) == 0;
            apply(ld, sel, psh, 16'($urandom), 16'($urandom), clr);
            check($sformatf("rand%0d", i), m_pc, m_q.size() == 0, m_q.size() == DEPTH, m_ovf, m_und);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
